// File: rtl/sw_input_conditioner.sv
// Switch synchroniser/debouncer, stretched CPU reset and single-cycle step enable.
// Optional heartbeat toggle flop when SW_COND_HEARTBEAT_EN is defined.
module sw_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned STEP_PERIOD     = 62500000,
  parameter int unsigned RST_HOLD        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  output logic [3:0] sw_db,
  output logic [3:0] sw_rise,
  output logic [3:0] sw_fall,
  output logic       cpu_reset,
  output logic       step_en,
  output logic       heartbeat
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int STEP_W = $clog2(STEP_PERIOD);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [3:0]        s1, s2;
  logic [DB_W-1:0]   db_cnt     [4];
  logic [DB_W-1:0]   db_cnt_nxt [4];
  logic [3:0]        db_flip;
  logic [HOLD_W-1:0] hold_cnt;
  logic              cpu_reset_nxt;
  logic [STEP_W-1:0] step_cnt, step_cnt_nxt;
  logic              step_nxt;
  logic              step_hold;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_flip[i]    = 1'b0;
      db_cnt_nxt[i] = '0;
      if (s2[i] != sw_db[i]) begin
        if (db_cnt[i] == DB_LAST) db_flip[i] = 1'b1;
        else                      db_cnt_nxt[i] = db_cnt[i] + 1'b1;
      end
    end
  end

  // NOTE: the counter array is four small flop registers, not RAM, so it is reset like any flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      sw_db   <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      db_cnt  <= db_cnt_nxt;
      sw_db   <= sw_db ^ db_flip;
      sw_rise <= db_flip & s2;
      sw_fall <= db_flip & ~s2;
    end
  end

  // cpu_reset deasserts on the edge the hold counter reaches zero.
  assign cpu_reset_nxt = sw_db[0] || (hold_cnt > HOLD_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt  <= HOLD_INIT;
      cpu_reset <= 1'b1;
    end else begin
      if (sw_db[0])             hold_cnt <= HOLD_INIT;
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - 1'b1;
      cpu_reset <= cpu_reset_nxt;
    end
  end

  // Gating on both the current and next cpu_reset keeps step_en low for the whole reset window
  // and starts the period count on the cycle after cpu_reset falls; a committing mode change
  // clears the count in the same cycle sw_db[1] shows the new mode.
  assign step_hold = cpu_reset || cpu_reset_nxt || db_flip[1];

  always_comb begin
    step_nxt     = 1'b0;
    step_cnt_nxt = '0;
    if (!step_hold) begin
      if (!sw_db[1]) begin
        if (step_cnt == STEP_LAST) step_nxt = 1'b1;
        else                       step_cnt_nxt = step_cnt + 1'b1;
      end else begin
        step_nxt = sw_rise[2] && !(sw_rise[1] || sw_fall[1]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt <= '0;
      step_en  <= 1'b0;
    end else begin
      step_cnt <= step_cnt_nxt;
      step_en  <= step_nxt;
    end
  end

`ifdef SW_COND_HEARTBEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              heartbeat <= 1'b0;
    else if (cpu_reset_nxt) heartbeat <= 1'b0;
    else if (step_nxt)      heartbeat <= ~heartbeat;
  end
`else
  assign heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Self-checking bench for sw_input_conditioner: directed scenarios plus random switch
// activity compared every cycle against a history-based reference model.
module tb_sw_input_conditioner;

  localparam int D = 4;
  localparam int P = 8;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw = 4'b0;
  logic [3:0] sw_db, sw_rise, sw_fall;
  logic       cpu_reset, step_en, heartbeat;

  int checks = 0;
  int errors = 0;

  sw_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .STEP_PERIOD    (P),
    .RST_HOLD       (H)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .sw_db    (sw_db),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .cpu_reset(cpu_reset),
    .step_en  (step_en),
    .heartbeat(heartbeat)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples kept as a history; a debounced bit flips once the last D
  // synchronised samples all disagree with it. Reset and step timing come from elapsed counts.
  logic [3:0] m_samp [0:D];
  logic [3:0] m_db, m_rise, m_fall;
  logic       m_cpu, m_step, m_hb;
  int         m_low, m_age;

  always @(posedge clk or posedge reset) begin : ref_model
    logic [3:0] flip;
    logic       cpu_n, run, st;
    int         low_n, age_n;
    if (reset) begin
      for (int j = 0; j <= D; j++) m_samp[j] <= '0;
      m_db <= '0; m_rise <= '0; m_fall <= '0;
      m_cpu <= 1'b1; m_step <= 1'b0; m_hb <= 1'b0;
      m_low <= 0; m_age <= 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        flip[i] = 1'b1;
        for (int j = 1; j <= D; j++) if (m_samp[j][i] == m_db[i]) flip[i] = 1'b0;
      end
      low_n = m_db[0] ? 0 : ((m_low < H) ? m_low + 1 : H);
      cpu_n = m_db[0] || (low_n < H);
      run   = !m_cpu && !cpu_n && !flip[1];
      age_n = (run && !m_db[1]) ? m_age + 1 : 0;
      st    = run && (m_db[1] ? (m_rise[2] && !m_rise[1] && !m_fall[1]) : (age_n % P == 0));
      m_samp[0] <= sw;
      for (int j = 1; j <= D; j++) m_samp[j] <= m_samp[j-1];
      m_db   <= m_db ^ flip;
      m_rise <= flip & ~m_db;
      m_fall <= flip & m_db;
      m_cpu  <= cpu_n;
      m_low  <= low_n;
      m_age  <= age_n;
      m_step <= st;
`ifdef SW_COND_HEARTBEAT_EN
      m_hb   <= cpu_n ? 1'b0 : (m_hb ^ st);
`else
      m_hb   <= 1'b0;
`endif
    end
  end

  logic [14:0] dut_v, mdl_v;
  assign dut_v = {sw_db, sw_rise, sw_fall, cpu_reset, step_en, heartbeat};
  assign mdl_v = {m_db, m_rise, m_fall, m_cpu, m_step, m_hb};

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] rst_v;
    rst_v = {12'b0, 1'b1, 1'b0, 1'b0};
    sw = 4'b0;
    @(negedge clk) reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (cpu_reset !== (k < H)) begin
        errors++;
        $display("FAIL reset_stretch k=%0d cpu_reset=%b want %b", k, cpu_reset, k < H);
      end
    end
    sw = 4'b1010;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dut_v !== rst_v) begin
      errors++;
      $display("FAIL async_reset got %b want %b", dut_v, rst_v);
    end
    sw = 4'b0;
    @(negedge clk) reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (dut_v !== mdl_v) begin
        errors++;
        $display("FAIL reset_model t=%0t got %b want %b", $time, dut_v, mdl_v);
      end
    end
  endtask

  task automatic test_debounce();
    sw[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (sw_db[3] !== (k >= 6) || sw_rise[3] !== (k == 6)) begin
        errors++;
        $display("FAIL debounce_edge k=%0d db=%b rise=%b want db=%b rise=%b",
                 k, sw_db[3], sw_rise[3], k >= 6, k == 6);
      end
    end
    sw[3] = 1'b0;
    repeat (10) @(negedge clk);
    sw[3] = 1'b1;
    repeat (3) @(negedge clk);
    sw[3] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (sw_db[3] !== 1'b0 || sw_rise[3] !== 1'b0 || dut_v !== mdl_v) begin
        errors++;
        $display("FAIL debounce_glitch k=%0d db=%b rise=%b want 0 0 (model %b got %b)",
                 k, sw_db[3], sw_rise[3], mdl_v, dut_v);
      end
    end
  endtask

  task automatic test_auto_step();
    int pulses = 0;
    sw = 4'b0;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      pulses += int'(step_en);
      checks++;
      if (step_en !== (k >= H + P && (k - H - P) % P == 0) || dut_v !== mdl_v) begin
        errors++;
        $display("FAIL auto_step k=%0d step_en=%b want %b (got %b model %b)",
                 k, step_en, (k >= H + P && (k - H - P) % P == 0), dut_v, mdl_v);
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL auto_step_count got %0d want 4", pulses);
    end
  endtask

  task automatic test_manual_step();
    int   pulses = 0;
    logic prev_rise = 1'b0;
    sw = 4'b0010;
    repeat (12) @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      for (int h = 0; h < 20; h++) begin
        sw[2] = (h < 10);
        @(negedge clk);
        pulses += int'(step_en);
        checks++;
        if ((step_en && !prev_rise) || dut_v !== mdl_v) begin
          errors++;
          $display("FAIL manual_step t=%0t step_en=%b prev_rise=%b got %b model %b",
                   $time, step_en, prev_rise, dut_v, mdl_v);
        end
        prev_rise = sw_rise[2];
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL manual_step_count got %0d want 3", pulses);
    end
  endtask

  task automatic test_cpu_reset_stretch();
    logic seen = 1'b0;
    sw = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ((cpu_reset && step_en) || dut_v !== mdl_v) begin
        errors++;
        $display("FAIL stretch_hold k=%0d cpu_reset=%b step_en=%b got %b model %b",
                 k, cpu_reset, step_en, dut_v, mdl_v);
      end
    end
    sw = 4'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (sw_fall[0]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stretch_fall_timeout sw_fall[0] never seen want 1");
    end
    for (int off = 0; off <= 3; off++) begin
      if (off > 0) @(negedge clk);
      checks++;
      if (cpu_reset !== (off < H) || step_en !== 1'b0) begin
        errors++;
        $display("FAIL stretch_release off=%0d cpu_reset=%b step_en=%b want %b 0",
                 off, cpu_reset, step_en, off < H);
      end
    end
    for (int k = 0; k < 30; k++) begin
      sw[0] = (k < 6) || (k >= 10 && k < 16);
      @(negedge clk);
      checks++;
      if (dut_v !== mdl_v) begin
        errors++;
        $display("FAIL stretch_retrigger k=%0d got %b want %b", k, dut_v, mdl_v);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic found = 1'b0;
    sw = 4'b0;
    do_reset();
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (step_en) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mode_first_pulse_timeout step_en never seen want 1");
    end
    repeat (2) @(negedge clk);
    sw[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (step_en !== 1'b0 || dut_v !== mdl_v) begin
        errors++;
        $display("FAIL mode_to_manual k=%0d step_en=%b want 0 (got %b model %b)",
                 k, step_en, dut_v, mdl_v);
      end
    end
    sw[1] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (sw_fall[1]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mode_fall_timeout sw_fall[1] never seen want 1");
    end
    for (int k = 1; k <= P; k++) begin
      @(negedge clk);
      checks++;
      if (step_en !== (k == P)) begin
        errors++;
        $display("FAIL mode_to_auto k=%0d step_en=%b want %b", k, step_en, k == P);
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 80; s++) begin
      sw = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0};
      repeat ($urandom_range(1, 8)) begin
        @(negedge clk);
        checks++;
        if (dut_v !== mdl_v) begin
          errors++;
          $display("FAIL random t=%0t sw=%b got %b want %b", $time, sw, dut_v, mdl_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_auto_step();
    test_manual_step();
    test_cpu_reset_stretch();
    test_mode_switch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sw_input_conditioner.md
Name: sw_input_conditioner

Overview:
- Upstream stage between the Zybo board switches and the CPU core.
- Synchronises and debounces the 4 slide switches, and produces a stretched CPU reset.
- Produces a single-cycle step enable that replaces a free-running divided clock, so the CPU can run on the board clock with a clock enable.
- Supports auto-step (periodic) and manual single-step modes.

Parameters:
- DEBOUNCE_CYCLES, 1250000: cycles an input must stay stable before the debounced value changes (10 ms at 125 MHz); must be >= 2.
- STEP_PERIOD, 62500000: board-clock cycles between auto-mode step pulses (0.5 s); must be >= 2.
- RST_HOLD, 16: cycles cpu_reset stays high after debounced sw[0] falls; must be >= 1.

Ports:
- clk  input  1  board clock, 125 MHz
- reset  input  1  asynchronous, active-high block reset
- sw  input  4  raw switches; [0] CPU reset request, [1] mode (0 auto, 1 manual), [2] manual step, [3] spare
- sw_db  output  4  debounced switch levels
- sw_rise  output  4  one-cycle pulse per bit on debounced 0->1
- sw_fall  output  4  one-cycle pulse per bit on debounced 1->0
- cpu_reset  output  1  registered reset to the CPU core
- step_en  output  1  one-cycle CPU clock enable
- heartbeat  output  1  step activity indicator (see Optional Feature)

Behaviour:
- Reset (async, active-high), all outputs registered:
  - sync flops, debounce counters, sw_db, sw_rise, sw_fall, step_en, step counter and heartbeat clear to 0.
  - cpu_reset goes to 1; its hold counter loads RST_HOLD.
- Synchroniser: 2 flops per bit (s1 then s2). No combinational path from sw to any output.
- Debounce, per bit i, each cycle:
  - If s2[i] == sw_db[i]: counter clears.
  - Else if counter == DEBOUNCE_CYCLES-1: sw_db[i] takes s2[i], the counter clears, and sw_rise[i] or sw_fall[i] is high for exactly that one cycle. The pulse appears in the same cycle sw_db first shows the new value.
  - Else: counter increments.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count; no pulse is produced.
  - Latency from a clean sw edge to the sw_db change: 2 + DEBOUNCE_CYCLES cycles.
  - Counter width: $clog2(DEBOUNCE_CYCLES).
- CPU reset:
  - While sw_db[0] == 1: cpu_reset = 1 and the hold counter reloads RST_HOLD.
  - After sw_db[0] falls: the hold counter decrements; cpu_reset drops in the cycle the counter reaches 0. cpu_reset is therefore high for exactly RST_HOLD cycles after sw_db[0] goes low.
  - After block reset with sw[0] = 0: cpu_reset is high for RST_HOLD cycles after reset deasserts.
  - If sw_db[0] re-rises during the hold, the hold restarts.
- Step generation. step_en is forced to 0 while cpu_reset is 1, and the step counter is held at 0.
  - Auto mode (sw_db[1] == 0): the counter runs 0..STEP_PERIOD-1 and wraps to 0. step_en is high for one cycle each time the counter is at STEP_PERIOD-1. The first pulse comes STEP_PERIOD cycles after cpu_reset drops.
  - Manual mode (sw_db[1] == 1): the counter is held at 0. step_en is high for one cycle in the cycle after sw_rise[2] (registered), and at no other time.
  - Mode change: the counter clears in the cycle sw_db[1] changes. No step_en is produced in that cycle, even if the counter was at STEP_PERIOD-1.
  - If sw_rise[2] coincides with an auto/manual change, the rise is ignored.
  - Holding sw[2] high produces no further pulses.
- step_en is never high on two consecutive cycles.

Optional Feature:
- Macro: SW_COND_HEARTBEAT_EN.
- Defined: heartbeat toggles on every cycle step_en is high; it resets to 0 and is held at 0 while cpu_reset is 1.
- Undefined: heartbeat is tied to constant 0 and no toggle flop is synthesised; all other behaviour is identical.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, STEP_PERIOD=8, RST_HOLD=3.
- Reset: assert reset mid-operation -> all outputs 0 except cpu_reset=1 immediately (asynchronous). Deassert with sw=0 -> cpu_reset falls exactly 3 cycles later.
- Debounce: sw[3] set 0->1 and held -> sw_db[3] and sw_rise[3] high at cycle 6 after the edge, and sw_rise[3] for 1 cycle only. A 3-cycle pulse on sw[3] -> sw_db and sw_rise never change.
- Auto step: sw=0 after reset -> step_en high on 1 of every 8 cycles, first pulse 8 cycles after cpu_reset falls. With SW_COND_HEARTBEAT_EN, heartbeat toggles at each pulse.
- Manual step: sw[1]=1 held, then sw[2] toggled 0->1 three times with clean 10-cycle levels -> exactly 3 step_en pulses, each 1 cycle after its sw_rise[2]. No pulses while sw[2] is held high.
- CPU reset stretch: sw[0] set high for 20 cycles, then low -> cpu_reset high throughout, low 3 cycles after sw_db[0] falls, step_en 0 throughout. sw[0] re-asserted during the hold -> hold restarts.
- Mode switch: auto to manual while the counter is at 7 -> no step_en in the switch cycle, counter reads 0 afterwards.
